// File: rtl/serial_regfile.sv
// Register file behind one serial {data, addr} shift register with a post-reset clear sweep.
// Optional: define SERIAL_REGFILE_AUTOINC_EN to post-increment the address field on every rd/wr.
`timescale 1ns/1ps
module serial_regfile #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic sdi,
  input  logic shift_en,
  input  logic rd,
  input  logic wr,
  output logic sdo,
  output logic busy,
  output logic done
);
  localparam int L     = DATA_W + ADDR_W;
  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic {CLEAR, IDLE} state_t;

  state_t              state_reg;
  logic [L-1:0]        sr_reg;
  logic [ADDR_W-1:0]   ptr_reg;
  logic                busy_reg;
  logic                done_reg;
  logic [DATA_W-1:0]   rf [DEPTH];

  logic [ADDR_W-1:0]   addr;
  logic [ADDR_W-1:0]   addr_next;
  logic [DATA_W-1:0]   data;
  logic                rf_we;
  logic [ADDR_W-1:0]   rf_waddr;
  logic [DATA_W-1:0]   rf_wdata;

  assign addr = sr_reg[ADDR_W-1:0];
  assign data = sr_reg[L-1:ADDR_W];

`ifdef SERIAL_REGFILE_AUTOINC_EN
  assign addr_next = addr + ADDR_W'(1);
`else
  assign addr_next = addr;
`endif

  // Single write port shared by the clear sweep and host writes; rd wins over wr.
  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = addr;
    rf_wdata = data;
    if (!rst) begin
      if (state_reg == CLEAR) begin
        rf_we    = 1'b1;
        rf_waddr = ptr_reg;
        rf_wdata = '0;
      end else if (wr && !rd) begin
        rf_we = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rf_we) begin
      rf[rf_waddr] <= rf_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= CLEAR;
      ptr_reg   <= '0;
      sr_reg    <= '0;
      busy_reg  <= 1'b1;
      done_reg  <= 1'b0;
    end else begin
      case (state_reg)
        CLEAR: begin
          done_reg <= 1'b0;
          ptr_reg  <= ptr_reg + ADDR_W'(1);
          if (&ptr_reg) begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
          end
        end
        IDLE: begin
          done_reg <= 1'b0;
          if (rd) begin
            sr_reg   <= {rf[addr], addr_next};
            done_reg <= 1'b1;
          end else if (wr) begin
            sr_reg[ADDR_W-1:0] <= addr_next;
            done_reg           <= 1'b1;
          end else if (shift_en) begin
            sr_reg <= {sr_reg[L-2:0], sdi};
          end
        end
        default: begin
          state_reg <= CLEAR;
          ptr_reg   <= '0;
          busy_reg  <= 1'b1;
        end
      endcase
    end
  end

  assign sdo  = sr_reg[L-1];
  assign busy = busy_reg;
  assign done = done_reg;
endmodule
